burst_sequencer: RTL
====================

// Module: burst_sequencer
// PURPOSE
//  Parametrised successor to the fixed-width synchroniser. Accepts one burst command from the real-time command register.
//  Waits until system TIME reaches the command's start time. Then emits N_impuls repetitions of blank1/radiate/blank2/receive.
//  Outputs are En_Iz/En_Pr windows plus DDS control. Adds abort, late-command rejection, zero-length phase skipping and coherent mode.
// PARAMETERS
//  TIMEW  64  width of system time and start time
//  TW     32  width of each interval counter (Ti, Tp, Tblank1, Tblank2), in CLK cycles
//  NW     16  width of pulse count and pulse index
// PORTS
//  CLK             in   1      system clock (48 MHz)
//  rst_n           in   1      asynchronous active-low reset
//  TIME            in   TIMEW  current system time; monotonic except at SYS_TIME_UPDATE jumps
//  cmd_valid       in   1      command present on cmd_* inputs
//  cmd_ready       out  1      block idle and able to accept; a transfer occurs when cmd_valid&&cmd_ready
//  cmd_time_start  in   TIMEW  start time
//  cmd_n           in   NW     number of pulses
//  cmd_type        in   2      0 = non-coherent, 1 = coherent, 2/3 = treated as 0
//  cmd_tb1         in   TW     Tblank1 length
//  cmd_ti          in   TW     radiate length
//  cmd_tb2         in   TW     Tblank2 length
//  cmd_tp          in   TW     receive length
//  abort           in   1      synchronous abort of current command
//  req_cmd         out  1      one-cycle request for the next command (to REQ_COMMAND of command register)
//  en_iz           out  1      radiate window
//  en_pr           out  1      receive window
//  dds_start       out  1      one-cycle DDS (re)start strobe
//  dds_en          out  1      DDS running level
//  pulse_idx       out  NW     index of current pulse, 0-based
//  busy            out  1      state != IDLE
//  done            out  1      one-cycle pulse: burst completed normally
//  late            out  1      one-cycle pulse: command rejected as already past
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0 except cmd_ready=1; pulse_idx=0. All outputs are registered.
//  - States: IDLE, ARM, TB1, IZ, TB2, PR, FIN.
//  - IDLE: cmd_ready=1. Accept cycle A is a cycle with cmd_valid&&cmd_ready.
//    - At A all cmd_* are latched. A cmd_type of 2 or 3 is latched as 0.
//    - If TIME > cmd_time_start at A: late=1 at A+1, stay IDLE, req_cmd=1 at A+1.
//    - Else go to ARM at A+1. cmd_ready=0 from A+1.
//  - ARM: let S be the first cycle with TIME >= latched start. From S+1 the block enters TB1 with pulse_idx=0.
//    - A TIME jump backwards while in ARM simply extends the wait; there is no re-check for lateness.
//  - Phase sequencing: each phase lasts exactly its latched length in cycles. The sequence is TB1 -> IZ -> TB2 -> PR.
//    - A phase of length 0 is skipped with no idle cycle. The next non-zero phase starts in the cycle the skipped one would have.
//    - en_iz=1 exactly during IZ cycles; en_pr=1 exactly during PR cycles; they are never both 1.
//    - After the last cycle of PR: if pulse_idx == n-1, go to FIN. Else increment pulse_idx and go to TB1.
//  - cmd_n == 0: from S+1 go directly to FIN; no windows and no DDS strobes.
//  - All four lengths 0 with n>0: go to FIN at S+1.
//  - DDS control:
//    - Type 0: dds_start=1 in the first cycle of each IZ. dds_en=1 during IZ only.
//    - Type 1: dds_start=1 in the first cycle of IZ of pulse 0 only. dds_en=1 from that cycle until FIN.
//    - If ti==0, no DDS strobe is issued for that pulse.
//  - FIN: lasts one cycle. done=1, req_cmd=1, outputs cleared, pulse_idx=0. Then IDLE with cmd_ready=1 next cycle.
//  - abort: when asserted in any non-IDLE state, the next cycle is IDLE.
//    - en_iz, en_pr, dds_en and dds_start are 0 in that next cycle. done stays 0 and req_cmd=1.
//    - abort is ignored in IDLE. abort in the same cycle as an accept is ignored; the command is taken.
//  - Counters are TW-bit down-counters loaded with length-1. A length of all ones is legal and gives 2^TW-1 cycles.
//  - Reset asserted mid-burst clears everything asynchronously. No done or req_cmd is issued for the aborted burst.
// TESTING
//  1. TIME counting from 0; cmd start=1000, n=10, type0, tb1=tb2=480, ti=tp=4800
//     -> 10 IZ windows of 4800 cycles each; first IZ starts 481 cycles after S; 10 dds_start pulses; done once.
//  2. Same command with type1
//     -> a single dds_start; dds_en high continuously from the first IZ until FIN.
//  3. TIME=2000 at accept, start=1500 -> late=1 and req_cmd=1 one cycle later; no en_iz or en_pr.
//  4. n=3, tb1=0, tb2=0, ti=5, tp=7 -> en_iz and en_pr alternate back-to-back with no gap cycles; pulse_idx steps 0,1,2.
//  5. abort in the 100th cycle of IZ of pulse 4
//     -> all windows are 0 on the next cycle; done=0; req_cmd=1; the next command is accepted cleanly.
//  6. rst_n dropped during PR, then a back-to-back command with n=0
//     -> outputs go 0 asynchronously; the n=0 command gives done at S+1 with no windows.

Source files
------------

// File: rtl/burst_sequencer.sv
// burst_sequencer
//   Takes one burst command from the real-time command register, waits until
//   system time reaches the command's start time, then plays n repetitions of
//   blank1 / radiate / blank2 / receive. Drives the radiate (en_iz) and receive
//   (en_pr) windows plus DDS control. Supports abort, late-command rejection,
//   skipping of zero-length phases and coherent DDS mode.
// Ports
//   CLK, rst_n                 48 MHz clock, asynchronous active-low reset
//   TIME                       current system time (TIMEW bits)
//   cmd_valid / cmd_ready      command handshake, transfer when both are 1
//   cmd_time_start, cmd_n,     start time, pulse count, type (1 = coherent),
//   cmd_type, cmd_tb1, cmd_ti, blank1 / radiate / blank2 / receive lengths
//   cmd_tb2, cmd_tp            in CLK cycles
//   abort                      synchronous abort of the running command
//   req_cmd                    one-cycle request for the next command
//   en_iz, en_pr               radiate and receive windows
//   dds_start, dds_en          DDS restart strobe and DDS run level
//   pulse_idx                  0-based index of the current pulse
//   busy, done, late           activity level, normal-completion and
//                              late-rejection strobes
module burst_sequencer #(
  parameter int TIMEW = 64,
  parameter int TW    = 32,
  parameter int NW    = 16
) (
  input  logic             CLK,
  input  logic             rst_n,
  input  logic [TIMEW-1:0] TIME,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [TIMEW-1:0] cmd_time_start,
  input  logic [NW-1:0]    cmd_n,
  input  logic [1:0]       cmd_type,
  input  logic [TW-1:0]    cmd_tb1,
  input  logic [TW-1:0]    cmd_ti,
  input  logic [TW-1:0]    cmd_tb2,
  input  logic [TW-1:0]    cmd_tp,
  input  logic             abort,
  output logic             req_cmd,
  output logic             en_iz,
  output logic             en_pr,
  output logic             dds_start,
  output logic             dds_en,
  output logic [NW-1:0]    pulse_idx,
  output logic             busy,
  output logic             done,
  output logic             late
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARM  = 3'd1,
    ST_TB1  = 3'd2,
    ST_IZ   = 3'd3,
    ST_TB2  = 3'd4,
    ST_PR   = 3'd5,
    ST_FIN  = 3'd6
  } state_t;

  // First non-empty phase at or after position 'from' (0=TB1 .. 3=PR).
  // ST_FIN means the rest of the pulse is empty.
  function automatic state_t pick_phase(input logic [2:0] from, input logic [3:0] nz);
    state_t res;
    if      ((from == 3'd0) && nz[0]) res = ST_TB1;
    else if ((from <= 3'd1) && nz[1]) res = ST_IZ;
    else if ((from <= 3'd2) && nz[2]) res = ST_TB2;
    else if ((from <= 3'd3) && nz[3]) res = ST_PR;
    else                              res = ST_FIN;
    return res;
  endfunction

  // Position of the phase that follows 's' within one pulse.
  function automatic logic [2:0] next_pos(input state_t s);
    logic [2:0] pos;
    case (s)
      ST_TB1:  pos = 3'd1;
      ST_IZ:   pos = 3'd2;
      ST_TB2:  pos = 3'd3;
      default: pos = 3'd4;
    endcase
    return pos;
  endfunction

  // Latched length of phase 's'.
  function automatic logic [TW-1:0] phase_len(input state_t s, input logic [TW-1:0] l_tb1,
                                              input logic [TW-1:0] l_ti, input logic [TW-1:0] l_tb2,
                                              input logic [TW-1:0] l_tp);
    logic [TW-1:0] len;
    case (s)
      ST_TB1:  len = l_tb1;
      ST_IZ:   len = l_ti;
      ST_TB2:  len = l_tb2;
      ST_PR:   len = l_tp;
      default: len = {TW{1'b0}};
    endcase
    return len;
  endfunction

  state_t           state_r;
  state_t           state_nxt_s;
  state_t           rest_s;
  logic [TIMEW-1:0] start_r;
  logic [NW-1:0]    n_r;
  logic             coh_r;
  logic [TW-1:0]    tb1_r;
  logic [TW-1:0]    ti_r;
  logic [TW-1:0]    tb2_r;
  logic [TW-1:0]    tp_r;
  logic [TW-1:0]    cnt_r;
  logic [TW-1:0]    cnt_nxt_s;
  logic [NW-1:0]    idx_r;
  logic [NW-1:0]    idx_nxt_s;
  logic [3:0]       nz_s;
  logic             accept_s;
  logic             too_late_s;
  logic             in_phase_s;
  logic             in_phase_nxt_s;
  logic             phase_end_s;
  logic             last_pulse_s;
  logic             abort_hit_s;
  logic             iz_enter_s;
  logic             cmd_ready_s;
  logic             busy_s;
  logic             en_iz_s;
  logic             en_pr_s;
  logic             done_s;
  logic             late_s;
  logic             req_cmd_s;
  logic             dds_start_s;
  logic             dds_en_s;

  assign accept_s       = cmd_valid && cmd_ready;
  assign too_late_s     = TIME > cmd_time_start;
  assign nz_s           = {(tp_r != {TW{1'b0}}), (tb2_r != {TW{1'b0}}),
                           (ti_r != {TW{1'b0}}), (tb1_r != {TW{1'b0}})};
  assign in_phase_s     = (state_r == ST_TB1) || (state_r == ST_IZ) ||
                          (state_r == ST_TB2) || (state_r == ST_PR);
  assign in_phase_nxt_s = (state_nxt_s == ST_TB1) || (state_nxt_s == ST_IZ) ||
                          (state_nxt_s == ST_TB2) || (state_nxt_s == ST_PR);
  assign phase_end_s    = in_phase_s && (cnt_r == {TW{1'b0}});
  assign last_pulse_s   = idx_r == (n_r - NW'(1));
  // Abort only applies to an active burst; in IDLE a simultaneous accept wins.
  assign abort_hit_s    = abort && (state_r != ST_IDLE);
  assign pulse_idx      = idx_r;

  // State register
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and pulse-index decode, including zero-length phase skipping
  always_comb begin
    state_nxt_s = state_r;
    idx_nxt_s   = idx_r;
    rest_s      = ST_FIN;
    case (state_r)
      ST_IDLE: begin
        if (accept_s && !too_late_s) state_nxt_s = ST_ARM;
        else                         state_nxt_s = ST_IDLE;
      end
      ST_ARM: begin
        if (abort_hit_s) begin
          state_nxt_s = ST_IDLE;
        end else if (TIME >= start_r) begin
          // n == 0 and an all-empty pulse both finish immediately
          if (n_r == {NW{1'b0}}) state_nxt_s = ST_FIN;
          else                   state_nxt_s = pick_phase(3'd0, nz_s);
        end else begin
          state_nxt_s = ST_ARM;
        end
      end
      ST_TB1, ST_IZ, ST_TB2, ST_PR: begin
        if (abort_hit_s) begin
          state_nxt_s = ST_IDLE;
        end else if (cnt_r == {TW{1'b0}}) begin
          rest_s = pick_phase(next_pos(state_r), nz_s);
          if (rest_s != ST_FIN) begin
            state_nxt_s = rest_s;
          end else if (last_pulse_s) begin
            state_nxt_s = ST_FIN;
          end else begin
            state_nxt_s = pick_phase(3'd0, nz_s);
            idx_nxt_s   = idx_r + NW'(1);
          end
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_FIN:  state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
    if (!in_phase_nxt_s) idx_nxt_s = {NW{1'b0}};
    else                 idx_nxt_s = idx_nxt_s;
  end

  // Interval down-counter: loaded with length-1 on entry to each phase
  always_comb begin
    if (in_phase_nxt_s && ((state_nxt_s != state_r) || phase_end_s))
      cnt_nxt_s = phase_len(state_nxt_s, tb1_r, ti_r, tb2_r, tp_r) - TW'(1);
    else if (in_phase_s)
      cnt_nxt_s = cnt_r - TW'(1);
    else
      cnt_nxt_s = cnt_r;
  end

  // Output decode from the next state so every port comes straight from a flop
  always_comb begin
    // A new IZ starts on entry from another phase or on IZ->IZ wrap into the next pulse
    iz_enter_s  = (state_nxt_s == ST_IZ) && ((state_r != ST_IZ) || phase_end_s);
    cmd_ready_s = state_nxt_s == ST_IDLE;
    busy_s      = state_nxt_s != ST_IDLE;
    en_iz_s     = state_nxt_s == ST_IZ;
    en_pr_s     = state_nxt_s == ST_PR;
    done_s      = state_nxt_s == ST_FIN;
    late_s      = accept_s && too_late_s;
    req_cmd_s   = done_s || late_s || abort_hit_s;
    dds_start_s = iz_enter_s && (!coh_r || (idx_nxt_s == {NW{1'b0}}));
    if (coh_r)
      dds_en_s = (iz_enter_s && (idx_nxt_s == {NW{1'b0}})) || (dds_en && in_phase_nxt_s);
    else
      dds_en_s = en_iz_s;
  end

  // Command latch, interval counter and pulse index
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      start_r <= {TIMEW{1'b0}};
      n_r     <= {NW{1'b0}};
      coh_r   <= 1'b0;
      tb1_r   <= {TW{1'b0}};
      ti_r    <= {TW{1'b0}};
      tb2_r   <= {TW{1'b0}};
      tp_r    <= {TW{1'b0}};
      cnt_r   <= {TW{1'b0}};
      idx_r   <= {NW{1'b0}};
    end else begin
      if (accept_s) begin
        start_r <= cmd_time_start;
        n_r     <= cmd_n;
        coh_r   <= (cmd_type == 2'd1);  // types 2 and 3 behave as non-coherent
        tb1_r   <= cmd_tb1;
        ti_r    <= cmd_ti;
        tb2_r   <= cmd_tb2;
        tp_r    <= cmd_tp;
      end
      cnt_r <= cnt_nxt_s;
      idx_r <= idx_nxt_s;
    end
  end

  // Output flops
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      en_iz     <= 1'b0;
      en_pr     <= 1'b0;
      done      <= 1'b0;
      late      <= 1'b0;
      req_cmd   <= 1'b0;
      dds_start <= 1'b0;
      dds_en    <= 1'b0;
    end else begin
      cmd_ready <= cmd_ready_s;
      busy      <= busy_s;
      en_iz     <= en_iz_s;
      en_pr     <= en_pr_s;
      done      <= done_s;
      late      <= late_s;
      req_cmd   <= req_cmd_s;
      dds_start <= dds_start_s;
      dds_en    <= dds_en_s;
    end
  end

endmodule
